// File: rtl/ram_pkg.sv
// Shared types and constants for the SRAM sequencer/arbiter.
// Port ids double as the round-robin last-served encoding.
package ram_pkg;
    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_PULSE = 3'd2,
        W_HOLD  = 3'd3,
        R_WAIT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/ram_rr_arb.sv
// Two-requester round-robin arbiter; the last-served register is reset
// to B so that the first contended grant after reset goes to A.
module ram_rr_arb
    import ram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_upd,
    input  logic i_upd_id,
    output logic o_grant,
    output logic o_grant_id
);
    logic r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       r_last <= PORT_B;
        else if (i_upd) r_last <= i_upd_id;
    end

    always_comb begin
        o_grant = i_req_a | i_req_b;
        if (i_req_a && i_req_b) o_grant_id = (r_last == PORT_A) ? PORT_B : PORT_A;
        else                    o_grant_id = i_req_a ? PORT_A : PORT_B;
    end
endmodule

// File: rtl/ram_arbiter.sv
// Two-port sequencer for an asynchronous SRAM: round-robin grant, counted
// CE/OE/WE strobe timing, data-bus ownership and per-port done/rdata.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SETUP_CYC = 2,
    parameter int WE_CYC    = 3,
    parameter int HOLD_CYC  = 1,
    parameter int READ_CYC  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              ram_en,
    output logic              ram_oe,
    output logic              ram_we
);
    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_port, r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata, r_a_rdata, r_b_rdata;
    logic               r_a_done, r_b_done;
    logic               w_grant, w_gid, w_sel_we, w_last, w_drv;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    function automatic logic [CNT_W-1:0] cnt_load(input state_t s);
        case (s)
            W_SETUP: return CNT_W'(SETUP_CYC - 1);
            W_PULSE: return CNT_W'(WE_CYC - 1);
            W_HOLD:  return CNT_W'(HOLD_CYC - 1);
            R_WAIT:  return CNT_W'(READ_CYC - 1);
            default: return '0;
        endcase
    endfunction

    ram_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_a    (a_req),
        .i_req_b    (b_req),
        .i_upd      (r_state == DONE),
        .i_upd_id   (r_port),
        .o_grant    (w_grant),
        .o_grant_id (w_gid)
    );

    assign w_sel_we    = (w_gid == PORT_A) ? a_we    : b_we;
    assign w_sel_addr  = (w_gid == PORT_A) ? a_addr  : b_addr;
    assign w_sel_wdata = (w_gid == PORT_A) ? a_wdata : b_wdata;
    assign w_last      = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next = w_sel_we ? W_SETUP : R_WAIT;
            W_SETUP: if (w_last)  w_next = W_PULSE;
            W_PULSE: if (w_last)  w_next = W_HOLD;
            W_HOLD:  if (w_last)  w_next = DONE;
            R_WAIT:  if (w_last)  w_next = DONE;
            DONE:                 w_next = IDLE;
            default:              w_next = IDLE;
        endcase
    end

    // Command latch, per-state down-counter, read capture and done pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_port    <= PORT_A;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
        end else begin
            r_a_done <= (r_state == DONE) && (r_port == PORT_A);
            r_b_done <= (r_state == DONE) && (r_port == PORT_B);
            if (r_state == IDLE && w_grant) begin
                r_port  <= w_gid;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (r_state != w_next)   r_cnt <= cnt_load(w_next);
            else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
            if (r_state == R_WAIT && w_last) begin
                if (r_port == PORT_A) r_a_rdata <= ram_data;
                else                  r_b_rdata <= ram_data;
            end
        end
    end

    // Strobes decode straight from state so reset releases the pins at once.
    always_comb begin
        ram_en = 1'b1;
        ram_oe = 1'b1;
        ram_we = 1'b1;
        w_drv  = 1'b0;
        case (r_state)
            W_SETUP, W_HOLD: begin ram_en = 1'b0; w_drv = 1'b1; end
            W_PULSE:         begin ram_en = 1'b0; ram_we = 1'b0; w_drv = 1'b1; end
            R_WAIT:          begin ram_en = 1'b0; ram_oe = 1'b0; end
            default: ;
        endcase
    end

    assign ram_data = w_drv ? r_wdata : 'z;
    assign ram_addr = r_addr;
    assign busy     = (r_state != IDLE);
    assign a_done   = r_a_done;
    assign b_done   = r_b_done;
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
    // r_we is kept for debug visibility of the latched command.
    logic w_unused;
    assign w_unused = r_we;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: SRAM model on the pins, shadow memory of completed
// writes, latency/alternation rules checked against randomized traffic.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [17:0] a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic        a_done, b_done, busy, ram_en, ram_oe, ram_we;
    logic [15:0] a_rdata, b_rdata;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;

    int checks = 0, errors = 0, viol = 0;
    logic [15:0] mem [0:(1<<18)-1];
    logic [15:0] ref_mem [logic [17:0]];
    logic [17:0] pool [0:7];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_rdata(b_rdata),
        .busy(busy), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we)
    );

    // Asynchronous SRAM: drives while CE/OE low, stores while CE/WE low.
    assign ram_data = (!ram_en && !ram_oe) ? mem[ram_addr] : 'z;
    always @(negedge clk) if (rst && !ram_en && !ram_we) mem[ram_addr] <= ram_data;

    // Bus-protocol watch: no OE/WE overlap, no contention while SRAM drives.
    always @(negedge clk) begin
        if (rst && !ram_oe && !ram_we) begin
            viol++; errors++;
            $display("FAIL strobe_overlap: oe=%b we=%b required not both 0", ram_oe, ram_we);
        end
        if (rst && !ram_oe && ram_data !== mem[ram_addr]) begin
            viol++; errors++;
            $display("FAIL bus_contention: data=%h required %h", ram_data, mem[ram_addr]);
        end
    end

    task automatic set_cmd(input bit p, input logic req, input logic we,
                           input logic [17:0] addr, input logic [15:0] wd);
        if (!p) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
        else    begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
    endtask

    function automatic logic get_done(input bit p);
        return p ? b_done : a_done;
    endfunction

    function automatic logic [15:0] get_rdata(input bit p);
        return p ? b_rdata : a_rdata;
    endfunction

    task automatic rand_cmd(output logic we, output logic [17:0] addr, output logic [15:0] wd);
        we = 1'($urandom_range(0, 1)); addr = pool[$urandom_range(0, 7)]; wd = 16'($urandom);
    endtask

    // One operation on port p, called at posedge+1; reports what the pins did.
    task automatic do_op(input bit p, input logic we, input logic [17:0] addr,
                         input logic [15:0] wd, input bit scramble,
                         output int lat, output int we_low, output int oe_low,
                         output int we_ofs, output int data_bad, output logic [15:0] rd);
        int n = 0, en_first = -1, we_first = -1;
        bit done = 0;
        we_low = 0; oe_low = 0; data_bad = 0; rd = 'x;
        set_cmd(p, 1'b1, we, addr, wd);
        while (n < 40 && !done) begin
            @(posedge clk); #1; n++;
            if (scramble && n == 1) set_cmd(p, 1'b1, 1'($urandom), 18'($urandom), 16'($urandom));
            if (!ram_en && en_first < 0) en_first = n;
            if (!ram_we) begin we_low++; if (we_first < 0) we_first = n; end
            if (!ram_oe) oe_low++;
            if (!ram_en && we && ram_data !== wd) data_bad++;
            if (get_done(p)) begin done = 1; rd = get_rdata(p); end
        end
        set_cmd(p, 1'b0, 1'b0, '0, '0);
        lat = done ? n - 1 : -1;
        we_ofs = we_first - en_first;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({ram_en, ram_oe, ram_we} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b required 111", {ram_en, ram_oe, ram_we}); end
        checks++; if (ram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", ram_addr); end
        checks++; if ({a_done, b_done, busy} !== 3'b000) begin errors++; $display("FAIL reset_done_busy: got %b required 000", {a_done, b_done, busy}); end
        checks++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h required 0/0", a_rdata, b_rdata); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        int lat, wl, ol, ofs, bad; logic [15:0] rd;
        do_op(1'b0, 1'b1, 18'h00012, 16'hBEEF, 1'b0, lat, wl, ol, ofs, bad, rd);
        ref_mem[18'h00012] = 16'hBEEF;
        checks++; if (lat !== 7) begin errors++; $display("FAIL write_latency: got %0d required 7", lat); end
        checks++; if (wl !== 3) begin errors++; $display("FAIL write_we_width: got %0d required 3", wl); end
        checks++; if (ofs !== 2) begin errors++; $display("FAIL write_setup: got %0d required 2", ofs); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL write_data_drive: got %0d bad cycles required 0", bad); end
        checks++; if (ol !== 0) begin errors++; $display("FAIL write_oe: got %0d oe-low cycles required 0", ol); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after: got %b required 0", busy); end
    endtask

    task automatic test_read_back();
        int lat, wl, ol, ofs, bad; logic [15:0] rd, a_before;
        a_before = a_rdata;
        do_op(1'b1, 1'b0, 18'h00012, 16'h0, 1'b0, lat, wl, ol, ofs, bad, rd);
        checks++; if (lat !== 4) begin errors++; $display("FAIL read_latency: got %0d required 4", lat); end
        checks++; if (ol !== 3) begin errors++; $display("FAIL read_oe_width: got %0d required 3", ol); end
        checks++; if (wl !== 0) begin errors++; $display("FAIL read_we: got %0d we-low cycles required 0", wl); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_data: got %h required beef", rd); end
        checks++; if (a_rdata !== a_before) begin errors++; $display("FAIL read_other_port: got %h required %h", a_rdata, a_before); end
    endtask

    task automatic test_random();
        int lat, wl, ol, ofs, bad; logic [15:0] rd, wd, other; logic we; logic [17:0] addr; bit p;
        for (int i = 0; i < 16; i++) begin
            p = 1'($urandom_range(0, 1));
            rand_cmd(we, addr, wd);
            other = get_rdata(~p);
            do_op(p, we, addr, wd, 1'b1, lat, wl, ol, ofs, bad, rd);
            checks++; if (lat !== (we ? 7 : 4)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, we ? 7 : 4); end
            checks++; if (get_rdata(~p) !== other) begin errors++; $display("FAIL rand_other_rdata[%0d]: got %h required %h", i, get_rdata(~p), other); end
            if (we) begin
                checks++; if (bad !== 0) begin errors++; $display("FAIL rand_wdata[%0d]: got %0d bad cycles required 0", i, bad); end
                ref_mem[addr] = wd;
            end else if (ref_mem.exists(addr)) begin
                checks++; if (rd !== ref_mem[addr]) begin errors++; $display("FAIL rand_rdata[%0d]: got %h required %h", i, rd, ref_mem[addr]); end
            end
        end
    endtask

    task automatic test_contention();
        logic       cw [2];
        logic [17:0] ca [2];
        logic [15:0] cd [2];
        int left [2];
        bit order [$];
        int n = 0;
        left[0] = 2; left[1] = 2;
        for (int p = 0; p < 2; p++) begin
            rand_cmd(cw[p], ca[p], cd[p]);
            set_cmd(1'(p), 1'b1, cw[p], ca[p], cd[p]);
        end
        while (n < 80 && (left[0] + left[1]) > 0) begin
            @(posedge clk); #1; n++;
            if (a_done && b_done) begin errors++; $display("FAIL dual_done: got both required one"); end
            for (int p = 0; p < 2; p++) begin
                if (get_done(1'(p))) begin
                    order.push_back(1'(p));
                    checks++; if (ram_en !== 1'b1) begin errors++; $display("FAIL gap_en: got %b required 1", ram_en); end
                    if (cw[p]) ref_mem[ca[p]] = cd[p];
                    else if (ref_mem.exists(ca[p])) begin
                        checks++; if (get_rdata(1'(p)) !== ref_mem[ca[p]]) begin errors++; $display("FAIL cont_rdata: got %h required %h", get_rdata(1'(p)), ref_mem[ca[p]]); end
                    end
                    left[p]--;
                    if (left[p] > 0) begin rand_cmd(cw[p], ca[p], cd[p]); set_cmd(1'(p), 1'b1, cw[p], ca[p], cd[p]); end
                    else set_cmd(1'(p), 1'b0, 1'b0, '0, '0);
                end
            end
        end
        checks++; if (order.size() != 4) begin errors++; $display("FAIL cont_count: got %0d required 4", order.size()); end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            checks++; if (order[i] !== 1'(i % 2)) begin errors++; $display("FAIL cont_order[%0d]: got %0d required %0d", i, order[i], i % 2); end
        end
    endtask

    task automatic test_turnaround();
        int lat, wl, ol, ofs, bad; logic [15:0] rd;
        do_op(1'b0, 1'b0, 18'h00012, 16'h0, 1'b0, lat, wl, ol, ofs, bad, rd);
        checks++; if (rd !== ref_mem[18'h00012]) begin errors++; $display("FAIL turn_read: got %h required %h", rd, ref_mem[18'h00012]); end
        do_op(1'b0, 1'b1, 18'h00013, 16'h1234, 1'b0, lat, wl, ol, ofs, bad, rd);
        ref_mem[18'h00013] = 16'h1234;
        checks++; if (lat !== 7) begin errors++; $display("FAIL turn_write_latency: got %0d required 7", lat); end
        do_op(1'b1, 1'b0, 18'h00013, 16'h0, 1'b0, lat, wl, ol, ofs, bad, rd);
        checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL turn_readback: got %h required 1234", rd); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL turn_protocol: got %0d violations required 0", viol); end
    endtask

    task automatic test_reset_mid_write();
        int lat, wl, ol, ofs, bad, n = 0, dcnt = 0; logic [15:0] rd;
        do_op(1'b0, 1'b1, 18'h00020, 16'h7777, 1'b0, lat, wl, ol, ofs, bad, rd);
        ref_mem[18'h00020] = 16'h7777;
        set_cmd(1'b0, 1'b1, 1'b1, 18'h2AAAA, 16'hA5C3);
        while (n < 20 && ram_we !== 1'b0) begin @(posedge clk); #1; n++; end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_reach_pulse: got we=%b required 0", ram_we); end
        rst = 1'b0;
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++; if ({ram_en, ram_oe, ram_we} !== 3'b111) begin errors++; $display("FAIL rst_mid_strobes: got %b required 111", {ram_en, ram_oe, ram_we}); end
        checks++; if (ram_data === 16'hA5C3) begin errors++; $display("FAIL rst_mid_bus: got %h required released", ram_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b required 0", busy); end
        ref_mem.delete(18'h2AAAA);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (a_done) dcnt++; end
        checks++; if (dcnt !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses required 0", dcnt); end
        // Both ports ask at once; reset must have re-armed the A preference.
        set_cmd(1'b0, 1'b1, 1'b0, 18'h00020, '0);
        set_cmd(1'b1, 1'b1, 1'b0, 18'h00012, '0);
        n = 0;
        while (n < 30 && !a_done && !b_done) begin @(posedge clk); #1; n++; end
        checks++; if ({a_done, b_done} !== 2'b10) begin errors++; $display("FAIL rst_first_grant: got a/b done %b required 10", {a_done, b_done}); end
        checks++; if (a_rdata !== 16'h7777) begin errors++; $display("FAIL rst_read_a: got %h required 7777", a_rdata); end
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0);
        n = 0;
        while (n < 30 && !b_done) begin @(posedge clk); #1; n++; end
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL rst_b_done: got %b required 1", b_done); end
        set_cmd(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_abort();
        int n = 0, dcnt = 0, first = -1;
        logic [15:0] wd;
        wd = 16'($urandom) | 16'h0001;
        set_cmd(1'b0, 1'b1, 1'b1, 18'h00055, wd);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1; n++;
            if (n == 1) set_cmd(1'b0, 1'b0, 1'b0, '0, '0);
            if (a_done) begin dcnt++; if (first < 0) first = n - 1; end
        end
        ref_mem[18'h00055] = wd;
        checks++; if (dcnt !== 1) begin errors++; $display("FAIL abort_done_count: got %0d required 1", dcnt); end
        checks++; if (first !== 7) begin errors++; $display("FAIL abort_latency: got %0d required 7", first); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
        checks++; if (mem[18'h00055] !== wd) begin errors++; $display("FAIL abort_stored: got %h required %h", mem[18'h00055], wd); end
    endtask

    initial begin
        pool[0] = 18'h00012; pool[1] = 18'h00013; pool[2] = 18'h00000; pool[3] = 18'h3FFFF;
        pool[4] = 18'h00100; pool[5] = 18'h20000; pool[6] = 18'h0ABCD; pool[7] = 18'h00020;
        test_reset();
        test_single_write();
        test_read_back();
        test_random();
        test_contention();
        test_turnaround();
        test_reset_mid_write();
        test_abort();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
